mem_wb: RTL and testbench
=========================

MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameter DATA_W, default 16: width of result, store-data, memory address and memory data buses.
REQ-002 Parameter TIMEOUT, default 15: maximum ACCESS-state cycles to wait for mem_rdy before abort.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 dst  input  DATA_W  EX-stage result; the memory address for ld/st.
REQ-006 sdata  input  DATA_W  EX-stage store data.
REQ-007 N, Z, V  input  1 each  EX-stage flags.
REQ-008 flags_we  input  1  instruction updates flags.
REQ-009 is_ld, is_st  input  1 each  instruction is load / store.
REQ-010 rf_we_in  input  1  instruction writes a register.
REQ-011 dst_reg  input  4  destination register index.
REQ-012 mem_rdy  input  1  data memory completes the current access.
REQ-013 mem_rdata  input  DATA_W  load data; valid when mem_rdy=1.
REQ-014 mem_re, mem_we  output  1 each  read / write request, registered.
REQ-015 mem_addr, mem_wdata  output  DATA_W  registered address / store data.
REQ-016 rf_we  output  1  register-file write strobe, registered.
REQ-017 rf_dst  output  4  register-file write index, registered.
REQ-018 rf_wdata  output  DATA_W  register-file write data, registered.
REQ-019 flag_N, flag_Z, flag_V  output  1 each  architectural flag register.
REQ-020 stall  output  1  freeze fetch/decode/EX; EX inputs hold while stall=1.
REQ-021 mem_err  output  1  one-cycle pulse on timeout or illegal ld+st.

Function
REQ-022 FSM SHALL have states IDLE, ACCESS, WB.
REQ-023 IDLE, no memory op: at the edge, rf_we<=rf_we_in, rf_dst<=dst_reg, rf_wdata<=dst (1-cycle latency); flags loaded from N/Z/V when flags_we=1, else held.
REQ-024 IDLE, exactly one of is_ld/is_st: stall=1 combinationally that cycle; at the edge capture mem_addr<=dst, mem_wdata<=sdata, rf_dst<=dst_reg, drive mem_re (ld) or mem_we (st), go to ACCESS, clear timeout counter; rf_we<=0.
REQ-025 IDLE, is_ld and is_st both 1: no access, no register write, mem_err pulses next cycle, remain IDLE, stall=0.
REQ-026 ACCESS: stall=1; mem_re/mem_we and mem_addr/mem_wdata held stable until mem_rdy sampled 1.
REQ-027 ACCESS, mem_rdy=1, load: capture rf_wdata<=mem_rdata, drop mem_re, go to WB.
REQ-028 ACCESS, mem_rdy=1, store: drop mem_we, go to IDLE; no register write.
REQ-029 ACCESS, counter reaches TIMEOUT with mem_rdy=0: drop requests, mem_err pulse, go to IDLE, no register write; mem_rdy on the same cycle wins over timeout.
REQ-030 WB: rf_we=1 for exactly one cycle, stall=1, then IDLE with stall=0.
REQ-031 Flags SHALL never change on ld/st instructions.
REQ-032 mem_re and mem_we SHALL never be 1 simultaneously.
REQ-033 mem_rdy outside ACCESS SHALL be ignored.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE; mem_re, mem_we, rf_we, mem_err, flags, counter = 0; mem_addr, mem_wdata, rf_wdata, rf_dst = 0; stall follows REQ-024 combinationally.
REQ-035 Reset mid-ACCESS SHALL abandon the access with no register write and no error pulse.

Structure
REQ-036 State encoding and DATA_W/TIMEOUT defaults SHALL live in the shared processor package.
REQ-037 One sub-module, flag_reg (3-bit enable-loaded flag register), is natural; FSM and counter stay in mem_wb.

Verification
REQ-038 ADD: dst=0x1234, dst_reg=3, rf_we_in=1, flags_we=1, N=0 Z=0 V=1 -> next cycle rf_we=1, rf_dst=3, rf_wdata=0x1234, flag_V=1, stall never 1.
REQ-039 LD: dst=0x0040, dst_reg=5, mem_rdy high after 2 ACCESS cycles, mem_rdata=0xBEEF -> mem_re held 2 cycles at addr 0x0040, then rf_we=1, rf_wdata=0xBEEF, then stall=0.
REQ-040 ST: dst=0x0010, sdata=0xA5A5, mem_rdy=1 first ACCESS cycle -> mem_we for 1 cycle, mem_wdata=0xA5A5, rf_we stays 0, flags unchanged.
REQ-041 LD with mem_rdy stuck 0 -> after 15 ACCESS cycles mem_err pulses once, mem_re drops, rf_we stays 0, stall=0.
REQ-042 rst_n low in 2nd ACCESS cycle -> mem_re=0 and state IDLE without waiting for clk; is_ld=is_st=1 -> mem_err pulse, no request.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared processor package: MEM/WB state encoding and default bus/timeout sizing.
package mem_wb_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wb_flag_reg.sv
// Architectural N/Z/V flag register, loaded only when en is high.
module flag_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 3'b000;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB stage: register writeback, single outstanding load/store with timeout, flag update.
//   state     | meaning
//   ST_IDLE   | pass ALU results to writeback, or launch a memory access
//   ST_ACCESS | request held on the bus until mem_rdy or timeout
//   ST_WB     | one-cycle register write of load data
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dst,
  input  logic [DATA_W-1:0] sdata,
  input  logic              N,
  input  logic              Z,
  input  logic              V,
  input  logic              flags_we,
  input  logic              is_ld,
  input  logic              is_st,
  input  logic              rf_we_in,
  input  logic [3:0]        dst_reg,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rf_we,
  output logic [3:0]        rf_dst,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_N,
  output logic              flag_Z,
  output logic              flag_V,
  output logic              stall,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             illegal;
  logic             timeout;
  logic             flags_en;

  assign mem_op   = is_ld ^ is_st;
  assign illegal  = is_ld & is_st;
  assign timeout  = (cnt == CNT_LAST);
  assign flags_en = (state == ST_IDLE) && flags_we && !is_ld && !is_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          stall     = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        // mem_rdy takes priority over an expiring timeout in the same cycle
        if (mem_rdy)      state_nxt = mem_re ? ST_WB : ST_IDLE;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_WB: begin
        stall     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_we     <= 1'b0;
      rf_dst    <= 4'd0;
      rf_wdata  <= '0;
      mem_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (illegal) begin
            rf_we   <= 1'b0;
            mem_err <= 1'b1;
          end else if (mem_op) begin
            mem_addr  <= dst;
            mem_wdata <= sdata;
            rf_dst    <= dst_reg;
            mem_re    <= is_ld;
            mem_we    <= is_st;
            cnt       <= '0;
            rf_we     <= 1'b0;
          end else begin
            rf_we    <= rf_we_in;
            rf_dst   <= dst_reg;
            rf_wdata <= dst;
          end
        end
        ST_ACCESS: begin
          rf_we <= 1'b0;
          if (mem_rdy) begin
            if (mem_re) begin
              rf_wdata <= mem_rdata;
              rf_we    <= 1'b1;
            end
            mem_re <= 1'b0;
            mem_we <= 1'b0;
          end else if (timeout) begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WB: begin
          rf_we <= 1'b0;
        end
        default: begin
          rf_we  <= 1'b0;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flags_en),
    .d     ({N, Z, V}),
    .q     ({flag_N, flag_Z, flag_V})
  );

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: directed ALU/load/store/timeout/reset/illegal sequences.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dst, sdata, mem_rdata;
  logic        N, Z, V, flags_we, is_ld, is_st, rf_we_in, mem_rdy;
  logic [3:0]  dst_reg;
  logic        mem_re, mem_we, rf_we, flag_N, flag_Z, flag_V, stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, rf_wdata;
  logic [3:0]  rf_dst;

  typedef struct { logic [3:0] idx; logic [15:0] data; } wr_t;
  wr_t rf_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk(clk), .rst_n(rst_n), .dst(dst), .sdata(sdata), .N(N), .Z(Z), .V(V),
    .flags_we(flags_we), .is_ld(is_ld), .is_st(is_st), .rf_we_in(rf_we_in),
    .dst_reg(dst_reg), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_wdata(rf_wdata),
    .flag_N(flag_N), .flag_Z(flag_Z), .flag_V(flag_V), .stall(stall), .mem_err(mem_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    dst = '0; sdata = '0; N = 0; Z = 0; V = 0; flags_we = 0;
    is_ld = 0; is_st = 0; rf_we_in = 0; dst_reg = '0;
  endtask

  // Monitor: every register write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_re && mem_we) chk("re_we_exclusive", {mem_re, mem_we}, 2'b00);
      if (rf_we === 1'b1) begin
        if (rf_q.size() == 0) begin
          chk("unexpected_rf_write", {rf_dst, rf_wdata}, 20'h0);
        end else begin
          wr_t e;
          e = rf_q.pop_front();
          chk("rf_dst", rf_dst, e.idx);
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_in();
    mem_rdy = 0; mem_rdata = '0;
    rst_n = 0;
    #2;
    chk("rst_outs", {mem_re, mem_we, rf_we, mem_err, stall, flag_N, flag_Z, flag_V}, 8'h00);
    chk("rst_buses", {mem_addr, mem_wdata, rf_wdata, rf_dst}, 52'h0);
    #10 rst_n = 1;
    step();

    // ADD with mem_rdy asserted outside ACCESS (must be ignored)
    dst = 16'h1234; dst_reg = 4'd3; rf_we_in = 1; flags_we = 1; V = 1; mem_rdy = 1;
    rf_q.push_back('{4'd3, 16'h1234});
    @(negedge clk) chk("add_stall", stall, 1'b0);
    step(); clear_in(); mem_rdy = 0;
    @(negedge clk) chk("add_flags", {flag_N, flag_Z, flag_V}, 3'b001);
    chk("add_stall_after", stall, 1'b0);

    // no-write ALU op, flags held
    step();
    dst = 16'h5555; N = 1; rf_we_in = 0; flags_we = 0;
    step(); clear_in();
    @(negedge clk) chk("hold_flags", {flag_N, flag_Z, flag_V}, 3'b001);

    // LD: ready in second ACCESS cycle
    step();
    is_ld = 1; dst = 16'h0040; dst_reg = 4'd5;
    @(negedge clk) chk("ld_stall_idle", stall, 1'b1);
    chk("ld_re_before", mem_re, 1'b0);
    step(); clear_in();
    @(negedge clk) chk("ld_acc1", {mem_re, mem_addr, stall}, {1'b1, 16'h0040, 1'b1});
    step();
    mem_rdy = 1; mem_rdata = 16'hBEEF;
    rf_q.push_back('{4'd5, 16'hBEEF});
    @(negedge clk) chk("ld_acc2", {mem_re, mem_addr, stall}, {1'b1, 16'h0040, 1'b1});
    step(); mem_rdy = 0; mem_rdata = '0;
    @(negedge clk) chk("ld_wb", {mem_re, stall, rf_we}, 3'b011);
    step();
    @(negedge clk) chk("ld_done", {stall, rf_we}, 2'b00);

    // ST with flag inputs that must be ignored
    is_st = 1; dst = 16'h0010; sdata = 16'hA5A5; flags_we = 1; N = 1; Z = 1; V = 0;
    step(); clear_in(); mem_rdy = 1;
    @(negedge clk) chk("st_acc", {mem_we, mem_re, mem_addr, mem_wdata}, {2'b10, 16'h0010, 16'hA5A5});
    step(); mem_rdy = 0;
    @(negedge clk) chk("st_done", {mem_we, stall, rf_we}, 3'b000);
    chk("st_flags", {flag_N, flag_Z, flag_V}, 3'b001);

    // LD timeout
    is_ld = 1; dst = 16'h0020; dst_reg = 4'd7;
    step(); clear_in();
    n = 0;
    @(negedge clk);
    while (mem_re === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 15);
    chk("to_err", {mem_err, stall, mem_re, rf_we}, 4'b1000);
    @(negedge clk) chk("to_err_pulse", mem_err, 1'b0);

    // LD with mem_rdy arriving on the last ACCESS cycle: ready wins
    step();
    is_ld = 1; dst = 16'h0030; dst_reg = 4'd9;
    step(); clear_in();
    repeat (14) step();
    mem_rdy = 1; mem_rdata = 16'h7777;
    rf_q.push_back('{4'd9, 16'h7777});
    @(negedge clk) chk("late_rdy_re", mem_re, 1'b1);
    step(); mem_rdy = 0;
    @(negedge clk) chk("late_rdy_noerr", {mem_err, rf_we, stall}, 3'b011);
    step();
    @(negedge clk) chk("late_rdy_done", stall, 1'b0);

    // ALU op updating all flags
    dst = 16'hFFFF; dst_reg = 4'hF; rf_we_in = 1; flags_we = 1; N = 1; Z = 1; V = 0;
    rf_q.push_back('{4'hF, 16'hFFFF});
    step(); clear_in();
    @(negedge clk) chk("flags_110", {flag_N, flag_Z, flag_V}, 3'b110);

    // reset during second ACCESS cycle
    step();
    is_ld = 1; dst = 16'h0080; dst_reg = 4'd2;
    step(); clear_in();
    @(negedge clk);
    step();
    #2 rst_n = 0;
    #1 chk("rst_mid", {mem_re, stall, mem_addr}, {1'b0, 1'b0, 16'h0000});
    chk("rst_mid_flags", {flag_N, flag_Z, flag_V}, 3'b000);
    @(negedge clk) rst_n = 1;
    @(negedge clk) chk("rst_mid_noerr", {mem_err, rf_we, mem_re}, 3'b000);
    @(negedge clk) chk("rst_mid_idle", {mem_err, stall}, 2'b00);

    // illegal ld+st
    step();
    is_ld = 1; is_st = 1; dst = 16'h0099; rf_we_in = 1; dst_reg = 4'd4;
    @(negedge clk) chk("ill_stall", stall, 1'b0);
    step(); clear_in();
    @(negedge clk) chk("ill_err", {mem_err, mem_re, mem_we, rf_we, stall}, 5'b10000);
    @(negedge clk) chk("ill_err_pulse", mem_err, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", rf_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
